change_dispenser: RTL and testbench

- Downstream stage of the vending controller. Accepts the refund amount produced after each sale and pays it out as physical coins, one coin per handshake.
- Coin denominations are 10, 5 and 1 dollars. Selection is greedy: largest coin first, limited by the on-board coin inventory.
- Coins go to the coin-motor driver through a valid/ack handshake. The block reports completion, plus a shortfall when the inventory cannot cover the refund.

---
 rtl/change_dispenser_pkg.sv | 14 +
 rtl/change_dispenser_coin_inventory.sv | 37 +++
 rtl/change_dispenser.sv | 117 +++++++++++
 tb/tb_change_dispenser.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: shared states, coin values and restock selector codes
package change_dispenser_pkg;

    typedef enum logic [2:0] {IDLE, PICK, WAIT, DONE, GAP} state_e;

    localparam logic [6:0] COIN_10 = 7'd10;
    localparam logic [6:0] COIN_5  = 7'd5;
    localparam logic [6:0] COIN_1  = 7'd1;

    localparam logic [1:0] SEL_10 = 2'b00;
    localparam logic [1:0] SEL_5  = 2'b01;
    localparam logic [1:0] SEL_1  = 2'b10;

endpackage

// File: rtl/change_dispenser_coin_inventory.sv
// coin_inventory: one saturating coin counter with restock add and single-coin decrement
module coin_inventory #(
    parameter int          W    = 6,
    parameter int unsigned INIT = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         add_i,
    input  logic [W-1:0] add_count_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         nonzero_o
);

    logic [W-1:0] count_q, count_d;
    logic [W:0]   sum;

    // restock saturates at all-ones; a decrement is never allowed to wrap below zero
    always_comb begin
        sum     = {1'b0, count_q} + {1'b0, add_count_i};
        count_d = count_q;
        if (add_i)
            count_d = sum[W] ? '1 : sum[W-1:0];
        else if (dec_i && count_q != '0)
            count_d = count_q - W'(1);
    end

    // counter register, reloads its initial stock on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) count_q <= W'(INIT);
        else         count_q <= count_d;
    end

    assign count_o   = count_q;
    assign nonzero_o = count_q != '0;

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund out greedily as 10/5/1 coins over a valid/ack handshake.
// Define DISPENSE_GAP_EN to insert a one-cycle settle gap between coins.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int INV_W   = 6,
    parameter int INIT_10 = 20,
    parameter int INIT_5  = 20,
    parameter int INIT_1  = 40
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             refund_valid_i,
    input  logic [6:0]       refund_amount_i,
    output logic             refund_ready_o,
    input  logic             restock_valid_i,
    input  logic [1:0]       restock_sel_i,
    input  logic [INV_W-1:0] restock_count_i,
    output logic             coin_valid_o,
    output logic [6:0]       coin_denom_o,
    input  logic             coin_ack_i,
    output logic             done_o,
    output logic             shortfall_o,
    output logic [6:0]       remaining_o,
    output logic [INV_W-1:0] inv_10_o,
    output logic [INV_W-1:0] inv_5_o,
    output logic [INV_W-1:0] inv_1_o
);

`ifdef DISPENSE_GAP_EN
    localparam state_e AFTER_COIN = GAP;
`else
    localparam state_e AFTER_COIN = PICK;
`endif

    state_e     state_q, state_d;
    logic [6:0] remaining_q, remaining_d;
    logic [6:0] denom_q, denom_d;
    logic       shortfall_q, shortfall_d;
    logic       nz_10, nz_5, nz_1;
    logic       restock_ok, paid;
    logic [6:0] pick_denom;

    assign pick_denom = (remaining_q >= COIN_10 && nz_10) ? COIN_10 :
                        (remaining_q >= COIN_5  && nz_5)  ? COIN_5  :
                        (remaining_q >= COIN_1  && nz_1)  ? COIN_1  : 7'd0;
    assign restock_ok = restock_valid_i && state_q == IDLE;
    assign paid       = state_q == WAIT && coin_ack_i;

    // next-state: latch refund, pick largest stocked coin that fits, retire it on ack
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        denom_d     = denom_q;
        shortfall_d = shortfall_q;
        case (state_q)
            IDLE: if (refund_valid_i) begin
                remaining_d = refund_amount_i;
                shortfall_d = 1'b0;
                state_d     = refund_amount_i == 7'd0 ? DONE : PICK;
            end
            PICK: begin
                denom_d     = pick_denom;
                shortfall_d = pick_denom == 7'd0;
                state_d     = pick_denom == 7'd0 ? DONE : WAIT;
            end
            WAIT: if (coin_ack_i) begin
                remaining_d = remaining_q - denom_q;
                state_d     = remaining_q == denom_q ? DONE : AFTER_COIN;
            end
            GAP:     state_d = PICK;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // control registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            remaining_q <= 7'd0;
            denom_q     <= 7'd0;
            shortfall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            denom_q     <= denom_d;
            shortfall_q <= shortfall_d;
        end
    end

    coin_inventory #(.W(INV_W), .INIT(INIT_10)) u_inv_10 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .add_i(restock_ok && restock_sel_i == SEL_10), .add_count_i(restock_count_i),
        .dec_i(paid && denom_q == COIN_10), .count_o(inv_10_o), .nonzero_o(nz_10)
    );

    coin_inventory #(.W(INV_W), .INIT(INIT_5)) u_inv_5 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .add_i(restock_ok && restock_sel_i == SEL_5), .add_count_i(restock_count_i),
        .dec_i(paid && denom_q == COIN_5), .count_o(inv_5_o), .nonzero_o(nz_5)
    );

    coin_inventory #(.W(INV_W), .INIT(INIT_1)) u_inv_1 (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .add_i(restock_ok && restock_sel_i == SEL_1), .add_count_i(restock_count_i),
        .dec_i(paid && denom_q == COIN_1), .count_o(inv_1_o), .nonzero_o(nz_1)
    );

    assign refund_ready_o = state_q == IDLE;
    assign coin_valid_o   = state_q == WAIT;
    assign coin_denom_o   = state_q == WAIT ? denom_q : 7'd0;
    assign done_o         = state_q == DONE;
    assign shortfall_o    = state_q == DONE && shortfall_q;
    assign remaining_o    = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench with a greedy-payout reference model
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       refund_valid = 1'b0;
    logic [6:0] refund_amount = '0;
    logic       refund_ready;
    logic       restock_valid = 1'b0;
    logic [1:0] restock_sel = '0;
    logic [5:0] restock_count = '0;
    logic       coin_valid;
    logic [6:0] coin_denom;
    logic       coin_ack = 1'b0;
    logic       done;
    logic       shortfall;
    logic [6:0] remaining;
    logic [5:0] inv_10, inv_5, inv_1;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk_i(clk), .rst_ni(rst_n),
        .refund_valid_i(refund_valid), .refund_amount_i(refund_amount), .refund_ready_o(refund_ready),
        .restock_valid_i(restock_valid), .restock_sel_i(restock_sel), .restock_count_i(restock_count),
        .coin_valid_o(coin_valid), .coin_denom_o(coin_denom), .coin_ack_i(coin_ack),
        .done_o(done), .shortfall_o(shortfall), .remaining_o(remaining),
        .inv_10_o(inv_10), .inv_5_o(inv_5), .inv_1_o(inv_1)
    );

    int passed = 0;
    int total = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    typedef struct {
        int sf;
        int rem;
        int i10;
        int i5;
        int i1;
    } done_t;

    int    m_inv[3];
    int    dv[3] = '{10, 5, 1};
    int    exp_coins[$];
    done_t exp_done[$];

    function automatic void m_reset();
        m_inv[0] = 20;
        m_inv[1] = 20;
        m_inv[2] = 40;
    endfunction

    function automatic void m_restock(input int sel, input int cnt);
        if (sel < 3) m_inv[sel] = (m_inv[sel] + cnt > 63) ? 63 : m_inv[sel] + cnt;
    endfunction

    function automatic void m_refund(input int amt);
        int    rem = amt;
        bit    found;
        done_t e;
        do begin
            found = 0;
            for (int k = 0; k < 3; k++)
                if (!found && dv[k] <= rem && m_inv[k] > 0) begin
                    found = 1;
                    exp_coins.push_back(dv[k]);
                    m_inv[k]--;
                    rem -= dv[k];
                end
        end while (found && rem > 0);
        e.sf  = rem != 0;
        e.rem = rem;
        e.i10 = m_inv[0];
        e.i5  = m_inv[1];
        e.i1  = m_inv[2];
        exp_done.push_back(e);
    endfunction

    // ack driver: raise ack ack_delay cycles after a coin request appears
    int ack_delay = 0;
    int ack_cnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (!coin_valid) begin
            coin_ack = 1'b0;
            ack_cnt  = 0;
        end else if (ack_cnt >= ack_delay) coin_ack = 1'b1;
        else ack_cnt++;
    end

    // monitor: checks each handshaked coin and each done pulse against the scoreboard
    int done_cnt = 0;
    int last_sf = -1;
    int last_rem = -1;
    bit prev_pend = 0;
    int prev_denom = 0;
    initial forever begin
        @(negedge clk);
        if (!rst_n) prev_pend = 0;
        else begin
            if (prev_pend) chk("denom_stable", coin_denom, prev_denom);
            if (!coin_valid) chk("denom_zero_when_idle", coin_denom, 0);
            if (coin_valid && coin_ack) begin
                chk("coin_expected", exp_coins.size() > 0, 1);
                if (exp_coins.size() > 0) chk("coin_denom", coin_denom, exp_coins.pop_front());
            end
            if (done) begin
                done_t e;
                done_cnt++;
                last_sf  = shortfall;
                last_rem = remaining;
                chk("done_expected", exp_done.size() > 0, 1);
                if (exp_done.size() > 0) begin
                    e = exp_done.pop_front();
                    chk("shortfall", shortfall, e.sf);
                    chk("remaining", remaining, e.rem);
                    chk("inv_10", inv_10, e.i10);
                    chk("inv_5", inv_5, e.i5);
                    chk("inv_1", inv_1, e.i1);
                    chk("coins_all_paid", exp_coins.size(), 0);
                end
            end
            prev_pend  = coin_valid && !coin_ack;
            prev_denom = coin_denom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int amt, input bit rv, input int rsel, input int rcnt);
        int n = 0;
        while (!refund_ready && n < 500) begin
            tick();
            n++;
        end
        chk("ready_before_issue", refund_ready, 1);
        refund_valid  = 1'b1;
        refund_amount = 7'(amt);
        restock_valid = rv;
        restock_sel   = 2'(rsel);
        restock_count = 6'(rcnt);
        if (rv) m_restock(rsel, rcnt);
        m_refund(amt);
        tick();
        refund_valid  = 1'b0;
        restock_valid = 1'b0;
    endtask

    task automatic wait_done(input int start);
        int n = 0;
        while (done_cnt == start && n < 3000) begin
            tick();
            n++;
        end
        chk("done_seen", done_cnt - start, 1);
    endtask

    task automatic refund(input int amt);
        int s = done_cnt;
        issue(amt, 0, 0, 0);
        wait_done(s);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!coin_valid && n < 100) begin
            tick();
            n++;
        end
        chk("coin_valid_seen", coin_valid, 1);
    endtask

    initial begin
        int s, lat, pre10;
        m_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_ready", refund_ready, 1);
        chk("rst_coin_valid", coin_valid, 0);
        chk("rst_coin_denom", coin_denom, 0);
        chk("rst_done", done, 0);
        chk("rst_shortfall", shortfall, 0);
        chk("rst_remaining", remaining, 0);
        chk("rst_inv_10", inv_10, 20);
        chk("rst_inv_5", inv_5, 20);
        chk("rst_inv_1", inv_1, 40);

        // refund 17, same-cycle ack: 10,5,1,1
        s = done_cnt;
        issue(17, 0, 0, 0);
        lat = 1;
        while (!coin_valid && lat < 10) begin
            tick();
            lat++;
        end
        chk("first_coin_latency", lat, 2);
        wait_done(s);
        chk("t17_inv_10", inv_10, 19);
        chk("t17_inv_5", inv_5, 19);
        chk("t17_inv_1", inv_1, 38);

        // zero refund: no coin, prompt done
        s = done_cnt;
        issue(0, 0, 0, 0);
        lat = 1;
        while (!done && lat < 10) begin
            chk("zero_no_coin", coin_valid, 0);
            tick();
            lat++;
        end
        chk("zero_done_latency_ok", lat <= 2, 1);
        wait_done(s);
        chk("zero_shortfall", last_sf, 0);

        // slow ack: coin held stable, exactly one done
        ack_delay = 5;
        s = done_cnt;
        refund(10);
        repeat (5) tick();
        chk("single_done", done_cnt - s, 1);

        // restock saturation on the 1-dollar counter
        restock_valid = 1'b1;
        restock_sel   = 2'b10;
        restock_count = 6'd60;
        m_restock(2, 60);
        tick();
        restock_valid = 1'b0;
        chk("inv_1_saturated", inv_1, 63);
        chk("inv_1_model", inv_1, m_inv[2]);

        // restock during WAIT is ignored
        ack_delay = 4;
        pre10 = m_inv[0];
        s = done_cnt;
        issue(10, 0, 0, 0);
        wait_valid();
        restock_valid = 1'b1;
        restock_sel   = 2'b00;
        restock_count = 6'd5;
        tick();
        restock_valid = 1'b0;
        chk("restock_in_wait_ignored", inv_10, pre10);
        wait_done(s);

        // reset while waiting on a coin ack
        ack_delay = 20;
        issue(25, 0, 0, 0);
        wait_valid();
        s = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_coin_valid", coin_valid, 0);
        chk("async_rst_denom", coin_denom, 0);
        chk("async_rst_remaining", remaining, 0);
        chk("async_rst_inv_10", inv_10, 20);
        chk("async_rst_inv_5", inv_5, 20);
        chk("async_rst_inv_1", inv_1, 40);
        exp_coins.delete();
        exp_done.delete();
        m_reset();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) tick();
        chk("no_done_after_reset", done_cnt - s, 0);

        // drain to 0/1/2 then refund 9 -> 5,1,1 and shortfall 2
        ack_delay = 0;
        repeat (9) refund(4);
        refund(2);
        refund(100);
        refund(100);
        refund(95);
        chk("drain_inv_10", inv_10, 0);
        chk("drain_inv_5", inv_5, 1);
        chk("drain_inv_1", inv_1, 2);
        refund(9);
        chk("short_flag", last_sf, 1);
        chk("short_remaining", last_rem, 2);
        chk("remaining_held", remaining, 2);

        // randomized refunds with restocks and varied ack delays
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                restock_valid = 1'b1;
                restock_sel   = 2'($urandom_range(0, 3));
                restock_count = 6'($urandom_range(0, 63));
                m_restock(int'(restock_sel), int'(restock_count));
                tick();
                restock_valid = 1'b0;
            end
            s = done_cnt;
            if ($urandom_range(0, 2) == 0)
                issue($urandom_range(0, 127), 1, $urandom_range(0, 3), $urandom_range(0, 63));
            else
                issue($urandom_range(0, 127), 0, 0, 0);
            wait_done(s);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
